// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: types shared by the MIPS Avalon bus masters.
//   bridge_state_t : bus-bridge FSM state encoding (IDLE, IFETCH, DREAD,
//                    DWRITE, COMMIT).
package mips_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFETCH = 3'd1,
    ST_DREAD  = 3'd2,
    ST_DWRITE = 3'd3,
    ST_COMMIT = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/mips_ibuf.sv
// mips_ibuf: direct-mapped instruction line buffer (one word per entry).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   flush               clear every valid bit on the next edge
//   lookup_addr         fetch address; lookup_hit/lookup_data are combinational
//   fill_en/addr/data   write one entry (tag+data, set valid)
//   inv_en/inv_addr     clear the valid bit of the entry holding inv_addr
module mips_ibuf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [DATA_W-1:0] lookup_data,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  // Index vectors need at least one bit even for a single-entry buffer.
  localparam int IW    = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  function automatic logic [IW-1:0] idx_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a >> OFF_W;
    return (IDX_W > 0) ? s[IW-1:0] : {IW{1'b0}};
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a >> (OFF_W + IDX_W);
    return s[TAG_W-1:0];
  endfunction

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [IW-1:0]     lk_idx, fill_idx, inv_idx;
  logic              inv_match;

  // Combinational lookup of the entry selected by the fetch address.
  always_comb begin
    lk_idx      = idx_of(lookup_addr);
    lookup_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == tag_of(lookup_addr));
    lookup_data = data_q[lk_idx];
  end

  // Next-state of the arrays; flush wins over a same-cycle fill so the
  // filled entry stays invalid.
  always_comb begin
    fill_idx  = idx_of(fill_addr);
    inv_idx   = idx_of(inv_addr);
    inv_match = inv_en && valid_q[inv_idx] && (tag_q[inv_idx] == tag_of(inv_addr));
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    if (flush) begin
      valid_d = {DEPTH{1'b0}};
    end else if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
    end else if (inv_match) begin
      valid_d[inv_idx] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (fill_en) begin
      tag_d[fill_idx]  = tag_of(fill_addr);
      data_d[fill_idx] = fill_data;
    end else begin
      tag_d  = tag_q;
      data_d = data_q;
    end
  end

  // Array storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= {TAG_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mips_bus_bridge.sv
// mips_bus_bridge: serialises a Harvard core's instruction fetch and data
// access onto one Avalon-MM master, freezing the core via cpu_clk_enable.
// Buffered instruction hits with no data request complete in one cycle.
// Ports:
//   clk, reset, flush            clock, async active-high reset, ibuf flush
//   cpu_*                        core side (fetch, load/store, clock enable)
//   waitrequest, readdata        Avalon slave responses
//   read, write, address,        Avalon commands (registered, zero when idle)
//   byteenable, writedata
module mips_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IBUF_DEPTH = 4,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  output logic              cpu_clk_enable,
  input  logic [ADDR_W-1:0] cpu_instr_address,
  output logic [DATA_W-1:0] cpu_instr_readdata,
  input  logic              cpu_data_read,
  input  logic              cpu_data_write,
  input  logic [ADDR_W-1:0] cpu_data_address,
  input  logic [BE_W-1:0]   cpu_data_byteenable,
  input  logic [DATA_W-1:0] cpu_data_writedata,
  output logic [DATA_W-1:0] cpu_data_readdata,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] writedata
);

  bridge_state_t     state_q, state_d;
  logic              read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [BE_W-1:0]   byteenable_q, byteenable_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [DATA_W-1:0] instr_hold_q, instr_hold_d;
  logic [DATA_W-1:0] data_hold_q, data_hold_d;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              fill_en, inv_en;

  mips_ibuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .lookup_addr(cpu_instr_address),
    .lookup_hit (hit),
    .lookup_data(hit_data),
    .fill_en    (fill_en),
    .fill_addr  (cpu_instr_address),
    .fill_data  (readdata),
    .inv_en     (inv_en),
    .inv_addr   (cpu_data_address)
  );

  // FSM next state, hold-register updates, and the command for the next
  // cycle; commands are derived from state_d so they are registered and
  // naturally held while the slave stalls (core inputs are frozen).
  always_comb begin
    state_d      = state_q;
    instr_hold_d = instr_hold_q;
    data_hold_d  = data_hold_q;
    fill_en      = 1'b0;
    inv_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hit) begin
          state_d = ST_IFETCH;
        end else if (cpu_data_read) begin
          state_d      = ST_DREAD;
          instr_hold_d = hit_data;
        end else if (cpu_data_write) begin
          state_d      = ST_DWRITE;
          instr_hold_d = hit_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IFETCH: begin
        if (!waitrequest) begin
          fill_en      = 1'b1;
          instr_hold_d = readdata;
          if (cpu_data_read) begin
            state_d = ST_DREAD;
          end else if (cpu_data_write) begin
            state_d = ST_DWRITE;
          end else begin
            state_d = ST_COMMIT;
          end
        end else begin
          state_d = ST_IFETCH;
        end
      end
      ST_DREAD: begin
        if (!waitrequest) begin
          data_hold_d = readdata;
          state_d     = ST_COMMIT;
        end else begin
          state_d = ST_DREAD;
        end
      end
      ST_DWRITE: begin
        if (!waitrequest) begin
          // A store over a buffered instruction makes that entry stale.
          inv_en  = 1'b1;
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_DWRITE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    read_d       = 1'b0;
    write_d      = 1'b0;
    address_d    = {ADDR_W{1'b0}};
    byteenable_d = {BE_W{1'b0}};
    writedata_d  = {DATA_W{1'b0}};
    case (state_d)
      ST_IFETCH: begin
        read_d       = 1'b1;
        address_d    = cpu_instr_address;
        byteenable_d = {BE_W{1'b1}};
      end
      ST_DREAD: begin
        read_d       = 1'b1;
        address_d    = cpu_data_address;
        byteenable_d = cpu_data_byteenable;
      end
      ST_DWRITE: begin
        write_d      = 1'b1;
        address_d    = cpu_data_address;
        byteenable_d = cpu_data_byteenable;
        writedata_d  = cpu_data_writedata;
      end
      default: begin
        read_d = 1'b0;
      end
    endcase
  end

  // State, command and hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= {ADDR_W{1'b0}};
      byteenable_q <= {BE_W{1'b0}};
      writedata_q  <= {DATA_W{1'b0}};
      instr_hold_q <= {DATA_W{1'b0}};
      data_hold_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      instr_hold_q <= instr_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

  // Core-side outputs; the IDLE hit path enables the core combinationally.
  always_comb begin
    if (state_q == ST_COMMIT) begin
      cpu_clk_enable = 1'b1;
    end else if (state_q == ST_IDLE) begin
      cpu_clk_enable = hit && !cpu_data_read && !cpu_data_write;
    end else begin
      cpu_clk_enable = 1'b0;
    end
    if (state_q == ST_IDLE) begin
      cpu_instr_readdata = hit ? hit_data : {DATA_W{1'b0}};
    end else begin
      cpu_instr_readdata = instr_hold_q;
    end
  end

  assign cpu_data_readdata = data_hold_q;
  assign read              = read_q;
  assign write             = write_q;
  assign address           = address_q;
  assign byteenable        = byteenable_q;
  assign writedata         = writedata_q;

endmodule
